// File: rtl/id_ex_pkg.sv
// id_ex_pkg: opcodes, instruction field positions, flag indices and the decode table
package id_ex_pkg;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SUBI = 5'b01001;
  localparam logic [4:0] OP_ANDI = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_LDI  = 5'b01100;
  localparam logic [4:0] OP_LDD  = 5'b01101;
  localparam logic [4:0] OP_STD  = 5'b01110;
  localparam logic [4:0] OP_ADD  = 5'b10000;
  localparam logic [4:0] OP_SUB  = 5'b10001;
  localparam logic [4:0] OP_AND  = 5'b10010;
  localparam logic [4:0] OP_OR   = 5'b10011;
  localparam logic [4:0] OP_EOR  = 5'b10110;
  localparam logic [4:0] OP_NOT  = 5'b11100;
  localparam logic [4:0] OP_SHL  = 5'b11101;
  localparam logic [4:0] OP_SHR  = 5'b11110;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int RD_HI = 10;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 5;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;
  typedef struct packed {
    logic legal;
    logic regwrite;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic use_rd;
    logic use_rs;
  } ctrl_t;
  function automatic ctrl_t decode(logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_NOT, OP_SHL, OP_SHR: c = '{1, 1, 0, 0, 0, 1, 0};
      OP_LDI: c = '{1, 1, 0, 0, 0, 0, 0};
      OP_LDD: c = '{1, 1, 1, 0, 1, 0, 0};
      OP_STD: c = '{1, 0, 0, 1, 0, 1, 0};
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR: c = '{1, 1, 0, 0, 0, 1, 1};
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/id_ex_if.sv
// id_ex_if: fetch-side, write-back and ID/EX output signals of id_ex_stage
interface id_ex_if #(parameter int DATA_W = 8);
  logic in_valid;
  logic in_ready;
  logic [15:0] instr;
  logic wb_en;
  logic [2:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic out_valid;
  logic out_ready;
  logic out_regwrite;
  logic out_mem_read;
  logic out_mem_write;
  logic out_mem_to_reg;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [2:0] out_rd;
  logic [2:0] out_flags;
  logic out_illegal;
  modport slave (
    input in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_regwrite, out_mem_read, out_mem_write, out_mem_to_reg,
    output out_alu_result, out_store_data, out_rd, out_flags, out_illegal
  );
  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input in_ready, out_valid, out_regwrite, out_mem_read, out_mem_write, out_mem_to_reg,
    input out_alu_result, out_store_data, out_rd, out_flags, out_illegal
  );
endinterface

// File: rtl/id_ex_alu.sv
// id_ex_alu: combinational ALU producing result and {Z,N,C}
module id_ex_alu import id_ex_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);
  logic c;
  logic fz;
  always_comb begin
    result = '0;
    c = 1'b0;
    fz = 1'b0;
    case (op)
      OP_ADDI, OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      OP_SUBI, OP_SUB: begin result = a - b; c = a < b; end
      OP_ANDI, OP_AND: result = a & b;
      OP_ORI, OP_OR:   result = a | b;
      OP_EOR:          result = a ^ b;
      OP_LDI:          result = b;
      OP_LDD, OP_STD:  begin result = b; fz = 1'b1; end
      OP_NOT:          result = ~a;
      OP_SHL:          {c, result} = {a, 1'b0};
      OP_SHR:          begin result = a >> 1; c = a[0]; end
      default:         fz = 1'b1;
    endcase
    flags = fz ? 3'b000 : {result == '0, result[DATA_W-1], c};
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/execute stage with register file, hazard scoreboard and ID/EX register; ID_EX_BYPASS_EN enables write-back bypass
module id_ex_stage import id_ex_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int IMM_W    = 8
) (
  input logic clk,
  input logic rst_n,
  id_ex_if.slave bus
);
  localparam logic [3:0] NR = 4'(NUM_REGS);
  logic [4:0] op;
  logic [2:0] rd, rs;
  ctrl_t c;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] rd_val, rs_val, imm, alu_b, res;
  logic [2:0] fl;
  logic [NUM_REGS-1:0] sb, sb_eff, sb_nxt;
  logic [7:0] sb8, clr8, set8;
  logic wb_ok, hazard, accept;
  assign op = bus.instr[OP_HI:OP_LO];
  assign rd = bus.instr[RD_HI:RD_LO];
  assign rs = bus.instr[RS_HI:RS_LO];
  assign c = decode(op);
  assign imm = DATA_W'(bus.instr[IMM_W-1:0]);
  // writes to indices beyond NUM_REGS are dropped, so those entries stay 0
  assign wb_ok = bus.wb_en & ({1'b0, bus.wb_addr} < NR);
  assign clr8 = 8'(wb_ok) << bus.wb_addr;
  assign set8 = 8'(accept & c.regwrite) << rd;
  assign sb_nxt = (sb & ~clr8[NUM_REGS-1:0]) | set8[NUM_REGS-1:0];
`ifdef ID_EX_BYPASS_EN
  assign rd_val = (wb_ok && bus.wb_addr == rd) ? bus.wb_data : rf[rd];
  assign rs_val = (wb_ok && bus.wb_addr == rs) ? bus.wb_data : rf[rs];
  assign sb_eff = sb & ~clr8[NUM_REGS-1:0];
`else
  assign rd_val = rf[rd];
  assign rs_val = rf[rs];
  assign sb_eff = sb;
`endif
  assign sb8 = 8'(sb_eff);
  assign hazard = bus.in_valid & (((c.use_rd | c.regwrite) & sb8[rd]) | (c.use_rs & sb8[rs]));
  assign bus.in_ready = (~bus.out_valid | bus.out_ready) & ~hazard;
  assign accept = bus.in_valid & bus.in_ready;
  assign alu_b = c.use_rs ? rs_val : imm;
  id_ex_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op),
    .a(rd_val),
    .b(alu_b),
    .result(res),
    .flags(fl)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      sb <= '0;
      bus.out_valid <= 1'b0;
      bus.out_regwrite <= 1'b0;
      bus.out_mem_read <= 1'b0;
      bus.out_mem_write <= 1'b0;
      bus.out_mem_to_reg <= 1'b0;
      bus.out_alu_result <= '0;
      bus.out_store_data <= '0;
      bus.out_rd <= '0;
      bus.out_flags <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      if (wb_ok) rf[bus.wb_addr] <= bus.wb_data;
      sb <= sb_nxt;
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_regwrite <= c.regwrite;
        bus.out_mem_read <= c.mem_read;
        bus.out_mem_write <= c.mem_write;
        bus.out_mem_to_reg <= c.mem_to_reg;
        bus.out_alu_result <= res;
        bus.out_store_data <= c.mem_write ? rd_val : '0;
        bus.out_rd <= rd;
        bus.out_flags <= fl;
        bus.out_illegal <= ~c.legal;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus with a queue scoreboard checked by an output monitor
module tb_id_ex_stage;
  import id_ex_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  id_ex_if #(.DATA_W(8)) bus ();
  id_ex_stage #(.DATA_W(8), .NUM_REGS(8), .IMM_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  logic [26:0] exp_q [$];
  string name_q [$];
  logic [26:0] act_v;
  assign act_v = {bus.out_regwrite, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg,
                  bus.out_illegal, bus.out_rd, bus.out_flags, bus.out_alu_result, bus.out_store_data};
  task automatic check(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask
  function automatic logic [26:0] ev(logic rw, logic mr, logic mw, logic m2r, logic ill,
                                     logic [2:0] rd, logic [2:0] fl, logic [7:0] res, logic [7:0] st);
    return {rw, mr, mw, m2r, ill, rd, fl, res, st};
  endfunction
  function automatic logic [26:0] alu_e(logic [2:0] rd, logic [2:0] fl, logic [7:0] res);
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd, fl, res, 8'h00);
  endfunction
  function automatic logic [15:0] ii(logic [4:0] op, logic [2:0] rd, logic [7:0] imm);
    return {op, rd, imm};
  endfunction
  function automatic logic [15:0] ir(logic [4:0] op, logic [2:0] rd, logic [2:0] rs);
    return {op, rd, rs, 5'b00000};
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", act_v);
      end else begin
        check(name_q.pop_front(), 32'(act_v), 32'(exp_q.pop_front()));
      end
    end
  end
  task automatic send(string n, logic [15:0] ins, logic [26:0] e);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.instr = ins;
    @(negedge clk);
    while (!bus.in_ready && t < 40) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout in_ready=0 required=1", n);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wb(logic [2:0] a, logic [7:0] d);
    bus.wb_en = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    @(posedge clk);
    #1 bus.wb_en = 1'b0;
  endtask
  task automatic op_wb(string n, logic [15:0] ins, logic [26:0] e);
    send(n, ins, e);
    wb(ins[10:8], e[15:8]);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_outputs", {4'b0, bus.out_valid, act_v}, 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op_wb("ldi_x1", ii(OP_LDI, 3'd1, 8'h33), alu_e(3'd1, 3'b000, 8'h33));
    op_wb("ldi_x2", ii(OP_LDI, 3'd2, 8'h01), alu_e(3'd2, 3'b000, 8'h01));
    op_wb("add_x2_x1", ir(OP_ADD, 3'd2, 3'd1), alu_e(3'd2, 3'b000, 8'h34));
    op_wb("ldi_x4", ii(OP_LDI, 3'd4, 8'hFF), alu_e(3'd4, 3'b010, 8'hFF));
    op_wb("addi_carry", ii(OP_ADDI, 3'd4, 8'h01), alu_e(3'd4, 3'b101, 8'h00));
    op_wb("ldi_x3", ii(OP_LDI, 3'd3, 8'h00), alu_e(3'd3, 3'b100, 8'h00));
    op_wb("subi_borrow", ii(OP_SUBI, 3'd3, 8'h01), alu_e(3'd3, 3'b011, 8'hFF));
    op_wb("ldi_x2_81", ii(OP_LDI, 3'd2, 8'h81), alu_e(3'd2, 3'b010, 8'h81));
    op_wb("shl_msb", ii(OP_SHL, 3'd2, 8'h00), alu_e(3'd2, 3'b001, 8'h02));
    send("ldd_x4", ii(OP_LDD, 3'd4, 8'h02), ev(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 3'b000, 8'h02, 8'h00));
    fork
      send("add_x2_x4", ir(OP_ADD, 3'd2, 3'd4), alu_e(3'd2, 3'b000, 8'h12));
      begin
        repeat (3) begin
          @(negedge clk);
          check("raw_stall_in_ready", 32'(bus.in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.wb_en = 1'b1;
        bus.wb_addr = 3'd4;
        bus.wb_data = 8'h10;
        @(negedge clk);
`ifdef ID_EX_BYPASS_EN
        check("wb_cycle_in_ready", 32'(bus.in_ready), 32'h1);
`else
        check("wb_cycle_in_ready", 32'(bus.in_ready), 32'h0);
`endif
        @(posedge clk);
        #1 bus.wb_en = 1'b0;
        @(negedge clk);
        check("post_wb_in_ready", 32'(bus.in_ready), 32'h1);
      end
    join
    @(posedge clk);
    #1;
    wb(3'd2, 8'h12);
    bus.out_ready = 1'b0;
    send("ldi_x5", ii(OP_LDI, 3'd5, 8'h55), alu_e(3'd5, 3'b000, 8'h55));
    bus.in_valid = 1'b1;
    bus.instr = ii(OP_LDI, 3'd6, 8'h66);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      check("bp_result_stable", 32'(bus.out_alu_result), 32'h55);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("resume_in_ready", 32'(bus.in_ready), 32'h1);
    exp_q.push_back(alu_e(3'd6, 3'b000, 8'h66));
    name_q.push_back("ldi_x6");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("no_bubble_out_valid", 32'(bus.out_valid), 32'h1);
    @(posedge clk);
    #1;
    wb(3'd5, 8'h55);
    wb(3'd6, 8'h66);
    send("illegal", ii(5'b11111, 3'd0, 8'h00), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'b000, 8'h00, 8'h00));
    op_wb("addi_x0_after_illegal", ii(OP_ADDI, 3'd0, 8'h05), alu_e(3'd0, 3'b000, 8'h05));
    send("std_x1", ii(OP_STD, 3'd1, 8'h01), ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'b000, 8'h01, 8'h33));
    op_wb("eor_x1_x2", ir(OP_EOR, 3'd1, 3'd2), alu_e(3'd1, 3'b000, 8'h21));
    op_wb("shr_lsb", ii(OP_SHR, 3'd1, 8'h00), alu_e(3'd1, 3'b001, 8'h10));
    op_wb("not_x1", ii(OP_NOT, 3'd1, 8'h00), alu_e(3'd1, 3'b010, 8'hEF));
    op_wb("andi_x1", ii(OP_ANDI, 3'd1, 8'h0F), alu_e(3'd1, 3'b000, 8'h0F));
    op_wb("ori_x1", ii(OP_ORI, 3'd1, 8'hF0), alu_e(3'd1, 3'b010, 8'hFF));
    op_wb("sub_self_zero", ir(OP_SUB, 3'd1, 3'd1), alu_e(3'd1, 3'b100, 8'h00));
    bus.out_ready = 1'b0;
    send("ldi_x7", ii(OP_LDI, 3'd7, 8'h77), alu_e(3'd7, 3'b000, 8'h77));
    bus.in_valid = 1'b1;
    bus.instr = ii(OP_ADDI, 3'd7, 8'h01);
    @(negedge clk);
    check("pre_reset_stall", 32'(bus.in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {4'b0, bus.out_valid, act_v}, 32'h0);
    exp_q.delete();
    name_q.delete();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    send("add_cleared_regs", ir(OP_ADD, 3'd1, 3'd7), alu_e(3'd1, 3'b100, 8'h00));
    send("addi_x7_cleared", ii(OP_ADDI, 3'd7, 8'h01), alu_e(3'd7, 3'b000, 8'h01));
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
